// File: rtl/shift_seq_if.sv
// Handshake and datapath bundle between the CPU control unit,
// the shift_seq sequencer and the combinational 8-bit rotate unit.
//   start/op/cnt/din : request from the control unit
//   sh_w/sh_cf       : result and carry from the rotate unit
//   sh_a/fbus/flbus/frbus : operand and controls to the rotate unit
//   dout/cf_out/busy/done : result and status back to the control unit
// master: control unit plus rotate unit side; slave: the sequencer.
interface shift_seq_if;
  logic       start;
  logic [1:0] op;
  logic [2:0] cnt;
  logic [7:0] din;
  logic [7:0] sh_w;
  logic       sh_cf;
  logic [7:0] sh_a;
  logic       fbus;
  logic       flbus;
  logic       frbus;
  logic [7:0] dout;
  logic       cf_out;
  logic       busy;
  logic       done;

  modport master (
    output start, op, cnt, din, sh_w, sh_cf,
    input  sh_a, fbus, flbus, frbus,
    input  dout, cf_out, busy, done
  );

  modport slave (
    input  start, op, cnt, din, sh_w, sh_cf,
    output sh_a, fbus, flbus, frbus,
    output dout, cf_out, busy, done
  );
endinterface

// File: rtl/shift_seq.sv
// Multi-cycle sequencer driving an 8-bit single-step rotate unit.
// Ports: clk, rst (async, active-high), bus (shift_seq_if.slave):
//   start/op/cnt/din in, sh_w/sh_cf from the rotate unit,
//   sh_a/fbus/flbus/frbus to the rotate unit,
//   dout/cf_out/busy/done back to the control unit.
module shift_seq (
  input  logic        clk,
  input  logic        rst,
  shift_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] work;
  logic [1:0] dir;
  logic [2:0] rem;
  logic [7:0] dout;
  logic       cf_out;
  logic       busy;
  logic       done;
  logic       fbus;
  logic       flbus;
  logic       frbus;
  logic       is_rot;

  // op 11 and a zero count both degrade to a single pass cycle
  assign is_rot = (bus.op == 2'b01) || (bus.op == 2'b10);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      work   <= 8'h00;
      dir    <= 2'b00;
      rem    <= 3'd0;
      dout   <= 8'h00;
      cf_out <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      fbus   <= 1'b0;
      flbus  <= 1'b0;
      frbus  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            work <= bus.din;
            dir  <= bus.op;
            rem  <= bus.cnt;
            busy <= 1'b1;
            if (is_rot && (bus.cnt != 3'd0)) begin
              state <= RUN;
              frbus <= (bus.op == 2'b01);
              flbus <= (bus.op == 2'b10);
            end else begin
              state <= PASS;
              fbus  <= 1'b1;
            end
          end
        end
        RUN: begin
          // rotate unit output becomes next step's operand
          work <= bus.sh_w;
          rem  <= rem - 3'd1;
          if (rem == 3'd1) begin
            state  <= DONE;
            dout   <= bus.sh_w;
            cf_out <= bus.sh_cf;
            done   <= 1'b1;
            frbus  <= 1'b0;
            flbus  <= 1'b0;
          end else begin
            frbus <= (dir == 2'b01);
            flbus <= (dir == 2'b10);
          end
        end
        PASS: begin
          state  <= DONE;
          work   <= bus.sh_w;
          dout   <= bus.sh_w;
          cf_out <= 1'b0;
          done   <= 1'b1;
          fbus   <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.sh_a   = work;
  assign bus.fbus   = fbus;
  assign bus.flbus  = flbus;
  assign bus.frbus  = frbus;
  assign bus.dout   = dout;
  assign bus.cf_out = cf_out;
  assign bus.busy   = busy;
  assign bus.done   = done;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq with a behavioural rotate unit
// and a whole-operation reference model.
module tb_shift_seq;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  shift_seq_if bus ();

  shift_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rotate unit; garbage when undriven so the sequencer must ignore it
  logic [8:0] junk;
  always @(negedge clk) junk = 9'($urandom);

  always_comb begin
    bus.sh_w  = junk[7:0];
    bus.sh_cf = junk[8];
    if (bus.frbus) begin
      bus.sh_w  = {bus.sh_a[0], bus.sh_a[7:1]};
      bus.sh_cf = bus.sh_a[0];
    end else if (bus.flbus) begin
      bus.sh_w  = {bus.sh_a[6:0], bus.sh_a[7]};
      bus.sh_cf = bus.sh_a[7];
    end else if (bus.fbus) begin
      bus.sh_w  = bus.sh_a;
    end
  end

  // Reference: {carry, result} of a whole operation
  function automatic logic [8:0] model(input logic [1:0] op,
                                       input logic [2:0] cnt,
                                       input logic [7:0] d);
    int          n;
    logic [15:0] dd;
    logic [15:0] sh;
    n  = int'(cnt);
    dd = {d, d};
    if ((op == 2'b01) && n != 0) begin
      sh = dd >> n;
      return {d[n-1], sh[7:0]};
    end else if ((op == 2'b10) && n != 0) begin
      sh = dd << n;
      return {d[8-n], sh[15:8]};
    end
    return {1'b0, d};
  endfunction

  function automatic int exp_cyc(input logic [1:0] op,
                                 input logic [2:0] cnt);
    if ((op == 2'b01 || op == 2'b10) && cnt != 3'd0)
      return int'(cnt) + 1;
    return 2;
  endfunction

  // Results of the last do_op
  int         done_cyc;
  int         ndone;
  int         nf, nl, nr;
  bit         multi;
  logic [7:0] got_dout;
  logic       got_cf;
  logic [7:0] shq[$];

  // Issue one request from the current negedge and follow it to done
  task automatic do_op(input logic [1:0] op, input logic [2:0] cnt,
                       input logic [7:0] din, input int inj_cyc,
                       input logic [7:0] inj_din);
    int c;
    bus.start = 1'b1;
    bus.op    = op;
    bus.cnt   = cnt;
    bus.din   = din;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    done_cyc = 0; ndone = 0;
    nf = 0; nl = 0; nr = 0; multi = 0;
    shq.delete();
    c = 1;
    while (c <= 20) begin
      nf += int'(bus.fbus);
      nl += int'(bus.flbus);
      nr += int'(bus.frbus);
      if (int'(bus.fbus) + int'(bus.flbus) + int'(bus.frbus) > 1)
        multi = 1;
      if (bus.fbus || bus.flbus || bus.frbus)
        shq.push_back(bus.sh_a);
      if (bus.done) begin
        ndone++;
        done_cyc = c;
        got_dout = bus.dout;
        got_cf   = bus.cf_out;
        bus.start = 1'b0;
        @(negedge clk);
        break;
      end
      if (c == inj_cyc) begin
        bus.start = 1'b1;
        bus.din   = inj_din;
        bus.op    = 2'($urandom);
        bus.cnt   = 3'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.cnt = 3'd0; bus.din = 8'h00;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.sh_a, bus.dout, bus.cf_out, bus.busy, bus.done,
         bus.fbus, bus.flbus, bus.frbus} !== 22'h0) begin
      errors++;
      $display("FAIL reset_state: got sh_a=%h dout=%h cf=%b busy=%b done=%b f=%b%b%b want all 0",
               bus.sh_a, bus.dout, bus.cf_out, bus.busy, bus.done,
               bus.fbus, bus.flbus, bus.frbus);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: got busy=%b dout=%h want 0/00",
               bus.busy, bus.dout);
    end
  endtask

  task automatic test_directed();
    logic [7:0] pd[3];
    logic [1:0] po[3];
    logic [2:0] pc[3];
    do_op(2'b01, 3'd1, 8'hA5, 0, 8'h00);
    vectors++;
    if (done_cyc !== 2 || got_dout !== 8'hD2 || got_cf !== 1'b1 ||
        nr !== 1 || nl !== 0 || nf !== 0) begin
      errors++;
      $display("FAIL ror1_A5: got cyc=%0d dout=%h cf=%b f/l/r=%0d/%0d/%0d want 2 D2 1 0/0/1",
               done_cyc, got_dout, got_cf, nf, nl, nr);
    end
    do_op(2'b10, 3'd3, 8'h81, 0, 8'h00);
    vectors++;
    if (done_cyc !== 4 || got_dout !== 8'h0C || got_cf !== 1'b0 ||
        nl !== 3 || nr !== 0 || nf !== 0) begin
      errors++;
      $display("FAIL rol3_81: got cyc=%0d dout=%h cf=%b f/l/r=%0d/%0d/%0d want 4 0C 0 0/3/0",
               done_cyc, got_dout, got_cf, nf, nl, nr);
    end
    vectors++;
    if (shq.size() != 3 || shq[0] !== 8'h81 || shq[1] !== 8'h03 ||
        shq[2] !== 8'h06) begin
      errors++;
      $display("FAIL rol3_sh_a_seq: got %p want 81 03 06", shq);
    end
    do_op(2'b01, 3'd7, 8'h01, 0, 8'h00);
    vectors++;
    if (done_cyc !== 8 || got_dout !== 8'h02 || got_cf !== 1'b0 ||
        nf !== 0 || nl !== 0 || nr !== 7) begin
      errors++;
      $display("FAIL ror7_01: got cyc=%0d dout=%h cf=%b f/l/r=%0d/%0d/%0d want 8 02 0 0/0/7",
               done_cyc, got_dout, got_cf, nf, nl, nr);
    end
    pd[0] = 8'h3C; po[0] = 2'b00; pc[0] = 3'd4;
    pd[1] = 8'h5A; po[1] = 2'b11; pc[1] = 3'd2;
    pd[2] = 8'h77; po[2] = 2'b10; pc[2] = 3'd0;
    for (int i = 0; i < 3; i++) begin
      do_op(po[i], pc[i], pd[i], 0, 8'h00);
      vectors++;
      if (done_cyc !== 2 || got_dout !== pd[i] || got_cf !== 1'b0 ||
          nf !== 1 || nl !== 0 || nr !== 0) begin
        errors++;
        $display("FAIL pass_%0d: got cyc=%0d dout=%h cf=%b f/l/r=%0d/%0d/%0d want 2 %h 0 1/0/0",
                 i, done_cyc, got_dout, got_cf, nf, nl, nr, pd[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [2:0] cnt;
    logic [7:0] d;
    logic [8:0] e;
    int         ec, enf, enl, enr;
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom);
      cnt = 3'($urandom);
      d   = 8'($urandom);
      e   = model(op, cnt, d);
      ec  = exp_cyc(op, cnt);
      enf = (ec == 2 && !((op == 2'b01 || op == 2'b10) && cnt == 3'd1))
            ? 1 : 0;
      enl = (op == 2'b10 && enf == 0) ? int'(cnt) : 0;
      enr = (op == 2'b01 && enf == 0) ? int'(cnt) : 0;
      do_op(op, cnt, d, 0, 8'h00);
      vectors++;
      if (done_cyc !== ec || got_dout !== e[7:0] || got_cf !== e[8] ||
          nf !== enf || nl !== enl || nr !== enr || multi ||
          shq.size() == 0 || shq[0] !== d) begin
        errors++;
        $display("FAIL random_%0d op=%b cnt=%0d din=%h: got cyc=%0d dout=%h cf=%b f/l/r=%0d/%0d/%0d multi=%b want %0d %h %b %0d/%0d/%0d",
                 i, op, cnt, d, done_cyc, got_dout, got_cf, nf, nl, nr,
                 multi, ec, e[7:0], e[8], enf, enl, enr);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [1:0] op;
    logic [7:0] d;
    logic [8:0] e;
    int         extra;
    op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    d  = 8'($urandom_range(0, 254));
    e  = model(op, 3'd5, d);
    do_op(op, 3'd5, d, 2, 8'hFF);
    vectors++;
    if (done_cyc !== 6 || got_dout !== e[7:0] || got_cf !== e[8]) begin
      errors++;
      $display("FAIL busy_ignore: got cyc=%0d dout=%h cf=%b want 6 %h %b",
               done_cyc, got_dout, got_cf, e[7:0], e[8]);
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      extra += int'(bus.done) + int'(bus.busy);
      @(negedge clk);
    end
    vectors++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL busy_single_done: got %0d extra busy/done cycles want 0",
               extra);
    end
  endtask

  task automatic test_midreset();
    logic [7:0] d;
    logic [8:0] e;
    int         seen;
    d = 8'($urandom);
    bus.start = 1'b1; bus.op = 2'b10; bus.cnt = 3'd6; bus.din = d;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.sh_a, bus.dout, bus.cf_out, bus.busy, bus.done,
         bus.fbus, bus.flbus, bus.frbus} !== 22'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got sh_a=%h dout=%h cf=%b busy=%b done=%b f=%b%b%b want all 0",
               bus.sh_a, bus.dout, bus.cf_out, bus.busy, bus.done,
               bus.fbus, bus.flbus, bus.frbus);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      seen += int'(bus.done) + int'(bus.busy);
      @(negedge clk);
    end
    vectors++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_no_done: got %0d busy/done cycles want 0",
               seen);
    end
    d = 8'($urandom);
    e = model(2'b01, 3'd4, d);
    do_op(2'b01, 3'd4, d, 0, 8'h00);
    vectors++;
    if (done_cyc !== 5 || got_dout !== e[7:0] || got_cf !== e[8]) begin
      errors++;
      $display("FAIL midreset_recover: got cyc=%0d dout=%h cf=%b want 5 %h %b",
               done_cyc, got_dout, got_cf, e[7:0], e[8]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] op;
    logic [2:0] cnt;
    logic [7:0] d;
    logic [8:0] e;
    for (int i = 0; i < 6; i++) begin
      op  = 2'($urandom);
      cnt = 3'($urandom);
      d   = 8'($urandom);
      e   = model(op, cnt, d);
      do_op(op, cnt, d, 0, 8'h00);
      vectors++;
      if (done_cyc !== exp_cyc(op, cnt) || got_dout !== e[7:0] ||
          got_cf !== e[8] || bus.busy !== 1'b0 || bus.dout !== e[7:0]) begin
        errors++;
        $display("FAIL b2b_%0d op=%b cnt=%0d din=%h: got cyc=%0d dout=%h cf=%b idle_busy=%b want %0d %h %b 0",
                 i, op, cnt, d, done_cyc, got_dout, got_cf, bus.busy,
                 exp_cyc(op, cnt), e[7:0], e[8]);
      end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.cnt   = 3'd0;
    bus.din   = 8'h00;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_midreset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
